run_detector_mc: RTL and testbench
==================================

RUN_DETECTOR_MC -- requirements
Module: run_detector_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of independent input channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning run-length counter width per channel (2..16); saturation value SAT = 2^CNT_W-1.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  meaning synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  meaning shared sample strobe; in_signal is sampled only when high.
REQ-006 The block SHALL have port in_signal  input  NCH  meaning one sample bit per channel.
REQ-007 The block SHALL have port cfg_we  input  1  meaning load cfg_threshold and cfg_polarity this cycle.
REQ-008 The block SHALL have port cfg_threshold  input  CNT_W  meaning run length required for detection.
REQ-009 The block SHALL have port cfg_polarity  input  1  meaning active level counted: 1 = runs of ones, 0 = runs of zeros.
REQ-010 The block SHALL have port out_signal  output  NCH  meaning per-channel detection level.
REQ-011 The block SHALL have port hit_pulse  output  NCH  meaning one-cycle pulse on each 0->1 transition of out_signal.
REQ-012 The block SHALL have port run_len  output  NCH*CNT_W  meaning per-channel current run count, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 The block SHALL have port any_hit  output  1  meaning OR of all out_signal bits.

Function
REQ-014 The block SHALL hold registered thr (CNT_W) and pol (1); on cfg_we=1 both SHALL load from cfg_threshold/cfg_polarity at the clock edge.
REQ-015 Per channel, the block SHALL keep a CNT_W-bit counter cnt[i] in one of three states: IDLE (cnt=0), COUNTING (0<cnt<thr), DETECTED (cnt>=thr, thr!=0).
REQ-016 On an edge with in_valid=1 and in_signal[i]==pol, cnt[i] SHALL increment by 1, saturating at SAT (no wrap).
REQ-017 On an edge with in_valid=1 and in_signal[i]!=pol, cnt[i] SHALL clear to 0.
REQ-018 On an edge with in_valid=0, cnt[i] SHALL hold.
REQ-019 On an edge with cfg_we=1, every cnt[i] SHALL clear to 0 regardless of in_valid; the new thr/pol apply from the next sample.
REQ-020 out_signal[i] SHALL be a Moore output: 1 iff thr!=0 and cnt[i]>=thr, derived from registered state only (no combinational path from in_signal).
REQ-021 Latency: a sample completing a run of length thr at edge k SHALL make out_signal[i]=1 in the cycle following edge k.
REQ-022 thr=0 SHALL disable detection: out_signal, hit_pulse, any_hit all 0; counters still run and saturate.
REQ-023 thr=SAT SHALL be legal; detection asserts when cnt saturates and holds while the run continues.
REQ-024 hit_pulse[i] SHALL be 1 for exactly one cycle in the cycle out_signal[i] rises; a held DETECTED state SHALL NOT re-pulse.
REQ-025 run_len SHALL equal the registered cnt values.
REQ-026 Channels SHALL be fully independent except for shared in_valid, thr, pol, cfg_we.

Reset
REQ-027 With reset_n=0 at a rising edge: all cnt=0, thr=2, pol=1, previous-out register=0; hence out_signal=0, hit_pulse=0, run_len=0, any_hit=0 from the next cycle.
REQ-028 Reset SHALL take priority over cfg_we and in_valid; reset mid-run SHALL discard the run.
REQ-029 Defaults thr=2, pol=1 SHALL give per-channel behaviour: out_signal high after 2 or more consecutive valid ones.

Verification
REQ-030 Defaults, NCH=4, ch0 inputs 1,1,1,0 on consecutive valid cycles -> out_signal[0]=0,1,1,0 after each edge; hit_pulse[0] once after 2nd edge; run_len[0]=1,2,3,0.
REQ-031 cfg thr=3, pol=0; ch1 zeros with in_valid toggling 1,0,1,0,1 -> cnt 1,1,2,2,3; out_signal[1] rises only after 5th edge.
REQ-032 CNT_W=2 (SAT=3), thr=3, 10 consecutive valid ones -> run_len sticks at 3, out_signal=1 throughout, single hit_pulse.
REQ-033 thr=0, continuous ones on all channels -> out_signal, hit_pulse, any_hit stay 0; run_len saturates at SAT.
REQ-034 Run at cnt=2 (detected), cfg_we=1 with thr=4 -> all cnt=0, out_signal=0 next cycle; 4 further ones -> detect.
REQ-035 Mid-run (cnt=3, detected) drive reset_n=0 one cycle with in_valid=1, in_signal=1 -> cnt=0, out_signal=0; release -> 2 more ones re-detect with new hit_pulse.

Source files
------------

// File: rtl/run_detector_mc.sv
// rtl/run_detector_mc.sv - multi-channel run-length detector with shared threshold/polarity
module run_detector_mc #(
    parameter int NCH   = 4,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [NCH-1:0]       in_signal,
    input  logic                 cfg_we,
    input  logic [CNT_W-1:0]     cfg_threshold,
    input  logic                 cfg_polarity,
    output logic [NCH-1:0]       out_signal,
    output logic [NCH-1:0]       hit_pulse,
    output logic [NCH*CNT_W-1:0] run_len,
    output logic                 any_hit
);

    localparam logic [CNT_W-1:0] SAT = '1;

    logic [CNT_W-1:0] thr;
    logic             pol;
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   prev_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            thr      <= CNT_W'(2);
            pol      <= 1'b1;
            prev_out <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            prev_out <= out_signal;
            if (cfg_we) begin
                // New settings take effect on a clean slate so no run straddles two configs.
                thr <= cfg_threshold;
                pol <= cfg_polarity;
                for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            end else if (in_valid) begin
                for (int i = 0; i < NCH; i++) begin
                    if (in_signal[i] == pol) begin
                        if (cnt[i] != SAT) cnt[i] <= cnt[i] + CNT_W'(1);
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Detection is a pure function of registered count and threshold.
    always_comb begin
        out_signal = '0;
        run_len    = '0;
        for (int i = 0; i < NCH; i++) begin
            out_signal[i]                  = (thr != '0) && (cnt[i] >= thr);
            run_len[i*CNT_W +: CNT_W]      = cnt[i];
        end
    end

    assign hit_pulse = out_signal & ~prev_out;
    assign any_hit   = |out_signal;

endmodule

// File: tb/tb_run_detector_mc.sv
// tb/tb_run_detector_mc.sv - randomized bench for run_detector_mc against a run-length model
module tb_run_detector_mc;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, cfg_we, cfg_polarity;
    logic [3:0]  in_signal, cfg_threshold;
    logic [1:0]  cfg_thr2;
    logic [3:0]  out_a, hit_a, out_b, hit_b;
    logic [15:0] len_a;
    logic [7:0]  len_b;
    logic        any_a, any_b;

    int checks_total  = 0;
    int checks_passed = 0;

    // Model: plain integer run lengths per instance/channel.
    int mcnt [2][4];
    int mthr [2];
    int msat [2];
    int mpol;
    bit mout [2][4];

    always #5 clk = ~clk;

    run_detector_mc #(.NCH(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_signal(in_signal),
        .cfg_we(cfg_we), .cfg_threshold(cfg_threshold), .cfg_polarity(cfg_polarity),
        .out_signal(out_a), .hit_pulse(hit_a), .run_len(len_a), .any_hit(any_a)
    );

    run_detector_mc #(.NCH(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_signal(in_signal),
        .cfg_we(cfg_we), .cfg_threshold(cfg_thr2), .cfg_polarity(cfg_polarity),
        .out_signal(out_b), .hit_pulse(hit_b), .run_len(len_b), .any_hit(any_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic v, input logic [3:0] s, input logic we,
                        input logic [3:0] t, input logic [1:0] t2, input logic p,
                        input logic rn);
        logic [3:0]  eo [2];
        logic [3:0]  eh [2];
        logic [15:0] el [2];
        @(negedge clk);
        reset_n = rn; in_valid = v; in_signal = s; cfg_we = we;
        cfg_threshold = t; cfg_thr2 = t2; cfg_polarity = p;
        @(posedge clk);
        if (!rn) begin
            mpol = 1;
            for (int k = 0; k < 2; k++) begin
                mthr[k] = 2;
                for (int c = 0; c < 4; c++) begin mcnt[k][c] = 0; mout[k][c] = 0; end
            end
        end else if (we) begin
            mpol = int'(p); mthr[0] = int'(t); mthr[1] = int'(t2);
            for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
        end else if (v) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 4; c++)
                    mcnt[k][c] = (int'(s[c]) == mpol) ?
                                 ((mcnt[k][c] + 1 > msat[k]) ? msat[k] : mcnt[k][c] + 1) : 0;
        end
        for (int k = 0; k < 2; k++) begin
            eo[k] = '0; eh[k] = '0; el[k] = '0;
            for (int c = 0; c < 4; c++) begin
                eo[k][c] = (mthr[k] != 0) && (mcnt[k][c] >= mthr[k]);
                eh[k][c] = rn && eo[k][c] && !mout[k][c];
                mout[k][c] = eo[k][c];
                if (k == 0) el[k][c*4 +: 4] = 4'(mcnt[k][c]);
                else        el[k][c*2 +: 2] = 2'(mcnt[k][c]);
            end
        end
        #1;
        check("out_a", 32'(out_a), 32'(eo[0]));
        check("hit_a", 32'(hit_a), 32'(eh[0]));
        check("len_a", 32'(len_a), 32'(el[0]));
        check("any_a", 32'(any_a), 32'(|eo[0]));
        check("out_b", 32'(out_b), 32'(eo[1]));
        check("hit_b", 32'(hit_b), 32'(eh[1]));
        check("len_b", 32'(len_b), 32'(el[1][7:0]));
        check("any_b", 32'(any_b), 32'(|eo[1]));
    endtask

    initial begin
        logic [3:0] s;
        logic       v, we, rn, p;
        msat[0] = 15; msat[1] = 3;
        reset_n = 1'b0; in_valid = 1'b0; in_signal = '0; cfg_we = 1'b0;
        cfg_threshold = '0; cfg_thr2 = '0; cfg_polarity = 1'b0;

        step(1, 4'hF, 1, 4'd7, 2'd1, 0, 0);
        check("reset_len_a", 32'(len_a), 32'd0);
        check("reset_out_a", 32'(out_a), 32'd0);

        // Defaults: ch0 sees 1,1,1,0.
        step(1, 4'h1, 0, 0, 0, 0, 1);
        step(1, 4'h1, 0, 0, 0, 0, 1);
        check("dflt_hit0", 32'(hit_a[0]), 32'd1);
        step(1, 4'h1, 0, 0, 0, 0, 1);
        check("dflt_len0", 32'(len_a[3:0]), 32'd3);
        step(1, 4'h0, 0, 0, 0, 0, 1);

        // thr=3, pol=0, zeros on ch1 with gapped valid.
        step(0, 4'h0, 1, 4'd3, 2'd3, 0, 1);
        step(1, 4'hD, 0, 0, 0, 0, 1);
        step(0, 4'hD, 0, 0, 0, 0, 1);
        step(1, 4'hD, 0, 0, 0, 0, 1);
        step(0, 4'hD, 0, 0, 0, 0, 1);
        check("gap_out1_pre", 32'(out_a[1]), 32'd0);
        step(1, 4'hD, 0, 0, 0, 0, 1);
        check("gap_out1", 32'(out_a[1]), 32'd1);

        // thr=SAT on both instances, long run of ones.
        step(0, 4'h0, 1, 4'd15, 2'd3, 1, 1);
        for (int i = 0; i < 18; i++) step(1, 4'hF, 0, 0, 0, 0, 1);
        check("sat_len_b", 32'(len_b), 32'hFF);

        // thr=0 disables detection while counters saturate.
        step(0, 4'h0, 1, 4'd0, 2'd0, 1, 1);
        for (int i = 0; i < 17; i++) step(1, 4'hF, 0, 0, 0, 0, 1);
        check("thr0_any", 32'(any_a), 32'd0);

        // Reconfigure mid-detection, then reset mid-run.
        step(0, 4'h0, 1, 4'd2, 2'd2, 1, 1);
        step(1, 4'hF, 0, 0, 0, 0, 1);
        step(1, 4'hF, 0, 0, 0, 0, 1);
        step(1, 4'hF, 1, 4'd4, 2'd2, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 4'hF, 0, 0, 0, 0, 1);
        check("recfg_out", 32'(out_a), 32'hF);
        step(1, 4'hF, 0, 0, 0, 0, 0);
        step(1, 4'hF, 0, 0, 0, 0, 1);
        step(1, 4'hF, 0, 0, 0, 0, 1);
        check("rst_rehit", 32'(hit_a), 32'hF);

        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (mpol != 0 ? 4'hF : 4'h0);
            we = ($urandom_range(0, 30) == 0);
            rn = ($urandom_range(0, 80) != 0);
            p  = 1'($urandom);
            step(v, s, we, 4'($urandom_range(0, 15)), 2'($urandom), p, rn);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
